d_sram_like_to_axi: RTL and testbench
=====================================

// Module: d_sram_like_to_axi
// PURPOSE
//  Responder for the CPU data-side SRAM-like bus: accepts one read/write at a time and issues it as a
//  single-beat AXI transaction. Sits between the SRAM-like initiator and the AXI crossbar/memory.
//  Strictly one outstanding transaction. data_ok is registered, so rdata is stable when data_ok is high.
// PARAMETERS
//  ID_W    4  width of arid/awid/rid/bid
//  RD_ID   0  arid value for all reads
//  WR_ID   1  awid value for all writes
// PORTS
//  clk         in   1     clock, all logic on rising edge
//  rst_n       in   1     asynchronous, active-low reset
//  data_req    in   1     SRAM-like request valid
//  data_wr     in   1     1 = write, 0 = read
//  data_size   in   2     0 = byte, 1 = half, 2 = word; 3 is treated as word
//  data_addr   in   32    byte address
//  data_wdata  in   32    write data, lane-aligned to the address
//  data_addr_ok  out  1   request accepted this cycle
//  data_data_ok  out  1   one-cycle pulse: transaction complete
//  data_rdata  out  32    read data, valid while data_data_ok is high, held until next read completes
//  arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/32/8/3/2/1; arready in 1
//  rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1; rready out 1
//  awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/32/8/3/2/1; awready in 1
//  wdata/wstrb/wlast/wvalid  out  32/4/1/1; wready in 1
//  bid/bresp/bvalid  in  ID_W/2/1; bready out 1
//  arlock/arcache/arprot, awlock/awcache/awprot  out  2/4/3 each, tied to 0
// BEHAVIOUR
//  FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP. Reset returns to IDLE.
//  Reset: all outputs and registers are 0.
//  IDLE: data_addr_ok = data_req (combinational). On accept, latch wr/size/addr/wdata.
//    Then go to RD_A if wr = 0, or WR_AW if wr = 1. addr_ok is never high outside IDLE.
//  RD_A: arvalid = 1 with latched address until arready; then go to RD_D.
//  RD_D: rready = 1. On rvalid, capture rdata into data_rdata and go to RESP.
//  WR_AW: awvalid and wvalid both assert in the first WR_AW cycle; each drops after its own handshake.
//    Handshakes are tracked by aw_done/w_done flags; either order, or the same cycle, is legal.
//    When both handshakes are complete, go to WR_B.
//  WR_B: bready = 1; on bvalid go to RESP.
//  RESP: data_data_ok = 1 for exactly one cycle, then go to IDLE. A new accept is possible the next cycle.
//  Latency with zero-wait AXI: read and write both take 4 cycles from the accept cycle to data_ok.
//  AXI fields:
//    arlen/awlen = 0, burst = 2'b01, wlast = 1.
//    arsize/awsize = {1'b0, size}, with size 3 mapped to 3'b010.
//  wstrb:
//    byte  = 4'b0001 << addr[1:0]
//    half  = addr[1] ? 4'b1100 : 4'b0011
//    word  = 4'b1111
//  A half access with addr[0] = 1 is issued unchanged; alignment is the initiator's duty.
//  rresp/bresp nonzero: ignored, the transaction completes normally.
//  rid/bid: not checked.
//  data_wdata is sampled only at accept; later changes on the input are ignored.
//  Reset asserted mid-transaction: FSM goes to IDLE and all valids drop at once. No data_ok is produced.
// CONFIGURATION
//  SRAM_LIKE_ADDR_MAP_EN
//    Defined: MIPS kseg0/kseg1 mapping is applied to the latched address.
//      If addr[31:30] = 2'b10, araddr/awaddr = {3'b000, addr[28:0]}; otherwise the address passes unchanged.
//    Undefined: araddr/awaddr equal the latched data_addr exactly.
// TESTING
//  T1 read: req, wr = 0, size = 2, addr = 0x0000_1004; AXI returns 0xDEAD_BEEF with zero wait.
//     -> arsize = 2, data_ok pulses 4 cycles after accept, data_rdata = 0xDEAD_BEEF.
//  T2 byte write: size = 0, addr = 0x0000_2003, wdata = 0xAA00_0000.
//     -> wstrb = 4'b1000, awsize = 0, wlast = 1, one data_ok pulse.
//  T3 split handshakes: awready 3 cycles before wready.
//     -> awvalid drops after its own handshake, wvalid stays high until wready, then bready.
//  T4 back-to-back: req held high across two reads.
//     -> the second addr_ok is the cycle after the first data_ok; never two outstanding.
//  T5 reset: rst_n low while in RD_D with rvalid = 0.
//     -> FSM in IDLE, arvalid/rready/data_ok = 0, data_rdata = 0.
//  T6 addr map: addr = 0xBFC0_0000.
//     -> with SRAM_LIKE_ADDR_MAP_EN: araddr = 0x1FC0_0000; without it: araddr = 0xBFC0_0000.

Source files
------------

// File: rtl/d_sram_like_to_axi.sv
// d_sram_like_to_axi: SRAM-like data-bus responder that issues each request as a
// single-beat AXI read or write. Strictly one transaction outstanding.
// Optional feature macro: SRAM_LIKE_ADDR_MAP_EN (MIPS kseg0/kseg1 physical mapping
// of the latched address before it is driven onto araddr/awaddr).
module d_sram_like_to_axi #(
  parameter int unsigned     ID_W  = 4,
  parameter logic [ID_W-1:0] RD_ID = '0,
  parameter logic [ID_W-1:0] WR_ID = ID_W'(1)
) (
  input  logic            clk,
  input  logic            rst_n,
  // SRAM-like side
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [31:0]     data_addr,
  input  logic [31:0]     data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [31:0]     data_rdata,
  // AXI read address
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  // AXI read data
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AXI write address
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  // AXI write data
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // AXI write response
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_A  = 3'd1;
  localparam logic [2:0] RD_D  = 3'd2;
  localparam logic [2:0] WR_AW = 3'd3;
  localparam logic [2:0] WR_B  = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  logic [2:0]  state_q,   state_d;
  logic [31:0] addr_q,    addr_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [2:0]  axsize_q,  axsize_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q,  w_done_d;
  logic        data_ok_q, data_ok_d;
  logic        aw_done_n, w_done_n;
  logic [31:0] axi_addr;

  // Response id/status and rlast carry no information for a single-beat, single-outstanding bridge.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  // Physical address seen on AXI, derived from the latched request address.
`ifdef SRAM_LIKE_ADDR_MAP_EN
  always_comb begin
    axi_addr = addr_q;
    if (addr_q[31:30] == 2'b10) begin
      axi_addr = {3'b000, addr_q[28:0]};
    end
  end
`else
  always_comb begin
    axi_addr = addr_q;
  end
`endif

  // Next-state, request latching and handshake tracking.
  // RESP spans two cycles: the first arms the registered data_ok pulse, the second
  // presents it and returns to IDLE, so a new accept can only follow the pulse.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    axsize_d  = axsize_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    data_ok_d = 1'b0;
    aw_done_n = aw_done_q | awready;
    w_done_n  = w_done_q | wready;
    case (state_q)
      IDLE: begin
        if (data_req) begin
          addr_d    = data_addr;
          wdata_d   = data_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          case (data_size)
            2'd0: begin
              axsize_d = 3'b000;
              wstrb_d  = 4'b0001 << data_addr[1:0];
            end
            2'd1: begin
              axsize_d = 3'b001;
              wstrb_d  = data_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
              axsize_d = 3'b010;
              wstrb_d  = 4'b1111;
            end
          endcase
          state_d = data_wr ? WR_AW : RD_A;
        end
      end
      RD_A: begin
        if (arready) begin
          state_d = RD_D;
        end
      end
      RD_D: begin
        if (rvalid) begin
          rdata_d = rdata;
          state_d = RESP;
        end
      end
      WR_AW: begin
        if (aw_done_n && w_done_n) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_B;
        end else begin
          aw_done_d = aw_done_n;
          w_done_d  = w_done_n;
        end
      end
      WR_B: begin
        if (bvalid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (data_ok_q) begin
          state_d = IDLE;
        end else begin
          data_ok_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      axsize_q  <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      axsize_q  <= axsize_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_ok_q <= data_ok_d;
    end
  end

  // SRAM-like outputs.
  assign data_addr_ok = (state_q == IDLE) && data_req;
  assign data_data_ok = data_ok_q;
  assign data_rdata   = rdata_q;

  // AXI read channels. Constant-valued fields are qualified by the owning state so
  // every output reads zero out of reset.
  assign arid    = (state_q == RD_A) ? RD_ID : '0;
  assign araddr  = axi_addr;
  assign arlen   = '0;
  assign arsize  = axsize_q;
  assign arburst = {1'b0, state_q == RD_A};
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = (state_q == RD_A);
  assign rready  = (state_q == RD_D);

  // AXI write channels.
  assign awid    = (state_q == WR_AW) ? WR_ID : '0;
  assign awaddr  = axi_addr;
  assign awlen   = '0;
  assign awsize  = axsize_q;
  assign awburst = {1'b0, state_q == WR_AW};
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awvalid = (state_q == WR_AW) && !aw_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = (state_q == WR_AW);
  assign wvalid  = (state_q == WR_AW) && !w_done_q;
  assign bready  = (state_q == WR_B);

endmodule

// File: tb/tb_d_sram_like_to_axi.sv
// Directed self-checking bench for d_sram_like_to_axi with a small AXI slave model.
module tb_d_sram_like_to_axi;

  localparam int unsigned ID_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            data_req, data_wr;
  logic [1:0]      data_size;
  logic [31:0]     data_addr, data_wdata;
  logic            data_addr_ok, data_data_ok;
  logic [31:0]     data_rdata;
  logic [ID_W-1:0] arid, awid, rid, bid;
  logic [31:0]     araddr, awaddr, rdata, wdata;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic [1:0]      arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]      arcache, awcache, wstrb;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  // slave model controls
  logic            r_hold;
  logic [31:0]     rd_val;
  logic            aw_seen, w_seen;

  int errors = 0;
  int checks = 0;

  d_sram_like_to_axi #(.ID_W(ID_W), .RD_ID(4'd0), .WR_ID(4'd1)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  assign rid   = 4'd0;
  assign bid   = 4'd1;
  assign rlast = rvalid;

  // Registered slave: R data one cycle after the AR handshake, B one cycle after both AW and W.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid  <= 1'b0;
      rdata   <= '0;
      bvalid  <= 1'b0;
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
    end else begin
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready && !r_hold) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
        bvalid  <= 1'b1;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end else begin
        if (awvalid && awready) aw_seen <= 1'b1;
        if (wvalid && wready)   w_seen  <= 1'b1;
      end
    end
  end

  // Counts negedges (from the call point) until data_data_ok is seen; -1 on timeout.
  task automatic wait_data_ok(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (data_data_ok) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = sz;
    data_addr  = a;
    data_wdata = wd;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, data_data_ok, data_addr_ok, wlast} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {arvalid, awvalid, wvalid, rready, bready, data_data_ok, data_addr_ok, wlast});
    end
    checks++;
    if ({araddr, awaddr, wdata, data_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {araddr, awaddr, wdata, data_rdata});
    end
    checks++;
    if ({wstrb, arsize, awsize, awid, arid, arburst, awburst} !== 22'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h required 0", {wstrb, arsize, awsize, awid, arid, arburst, awburst});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    int c;
    rd_val = 32'hDEAD_BEEF;
    rresp  = 2'b10;
    issue(1'b0, 2'd2, 32'h0000_1004, 32'h0);
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL rd_addr_ok: got %b required 1", data_addr_ok); end
    @(negedge clk);
    data_req = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_1004) begin
      errors++; $display("FAIL rd_ar: got arvalid=%b araddr=%h required 1 00001004", arvalid, araddr);
    end
    checks++;
    if (arsize !== 3'd2 || arlen !== 8'd0 || arburst !== 2'b01 || arid !== 4'd0) begin
      errors++; $display("FAIL rd_ar_fields: got size=%0d len=%0d burst=%b id=%0d required 2 0 01 0",
                         arsize, arlen, arburst, arid);
    end
    wait_data_ok(c);
    checks++;
    if (c !== 3) begin errors++; $display("FAIL rd_latency: got %0d required 4", c + 1); end
    checks++;
    if (data_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h required deadbeef", data_rdata); end
    @(negedge clk);
    checks++;
    if (data_data_ok !== 1'b0 || data_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_pulse_hold: got ok=%b data=%h required 0 deadbeef", data_data_ok, data_rdata);
    end
    rresp = 2'b00;
  endtask

  task automatic test_byte_write();
    int c;
    bresp = 2'b11;
    issue(1'b1, 2'd0, 32'h0000_2003, 32'hAA00_0000);
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL wr_addr_ok: got %b required 1", data_addr_ok); end
    @(negedge clk);
    data_req   = 1'b0;
    data_wdata = 32'h1234_5678;
    checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h0000_2003) begin
      errors++; $display("FAIL wr_valids: got aw=%b w=%b awaddr=%h required 1 1 00002003", awvalid, wvalid, awaddr);
    end
    checks++;
    if (wstrb !== 4'b1000 || awsize !== 3'd0 || wlast !== 1'b1) begin
      errors++; $display("FAIL wr_byte_fields: got strb=%b size=%0d last=%b required 1000 0 1", wstrb, awsize, wlast);
    end
    checks++;
    if (wdata !== 32'hAA00_0000 || awid !== 4'd1 || awburst !== 2'b01 || awlen !== 8'd0) begin
      errors++; $display("FAIL wr_data_fields: got wdata=%h id=%0d burst=%b len=%0d required aa000000 1 01 0",
                         wdata, awid, awburst, awlen);
    end
    wait_data_ok(c);
    checks++;
    if (c !== 3) begin errors++; $display("FAIL wr_latency: got %0d required 4", c + 1); end
    @(negedge clk);
    checks++;
    if (data_data_ok !== 1'b0) begin errors++; $display("FAIL wr_single_pulse: got %b required 0", data_data_ok); end
    bresp = 2'b00;
  endtask

  task automatic test_split_handshake();
    int c;
    wready = 1'b0;
    issue(1'b1, 2'd2, 32'h0000_3000, 32'h1122_3344);
    @(negedge clk);
    data_req = 1'b0;
    checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'b1111) begin
      errors++; $display("FAIL split_first: got aw=%b w=%b strb=%b required 1 1 1111", awvalid, wvalid, wstrb);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (awvalid !== 1'b0 || wvalid !== 1'b1 || bready !== 1'b0) begin
        errors++; $display("FAIL split_wait: got aw=%b w=%b b=%b required 0 1 0", awvalid, wvalid, bready);
      end
    end
    @(negedge clk);
    wready = 1'b1;
    checks++;
    if (wvalid !== 1'b1 || bready !== 1'b0) begin
      errors++; $display("FAIL split_wready: got w=%b b=%b required 1 0", wvalid, bready);
    end
    @(negedge clk);
    checks++;
    if (wvalid !== 1'b0 || awvalid !== 1'b0 || bready !== 1'b1) begin
      errors++; $display("FAIL split_bready: got aw=%b w=%b b=%b required 0 0 1", awvalid, wvalid, bready);
    end
    wait_data_ok(c);
    checks++;
    if (c !== 2) begin errors++; $display("FAIL split_done: got %0d required 2", c); end
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    rd_val = 32'h1111_1111;
    issue(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_first_accept: got %b required 1", data_addr_ok); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) data_addr = 32'h0000_0200;
      if (i == 2) rd_val = 32'h2222_2222;
      checks++;
      if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b required 0", data_addr_ok); end
    end
    @(negedge clk);
    checks++;
    if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b0 || data_rdata !== 32'h1111_1111) begin
      errors++; $display("FAIL b2b_first_done: got ok=%b aok=%b data=%h required 1 0 11111111",
                         data_data_ok, data_addr_ok, data_rdata);
    end
    @(negedge clk);
    checks++;
    if (data_addr_ok !== 1'b1 || data_data_ok !== 1'b0) begin
      errors++; $display("FAIL b2b_second_accept: got aok=%b ok=%b required 1 0", data_addr_ok, data_data_ok);
    end
    @(negedge clk);
    data_req = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_0200) begin
      errors++; $display("FAIL b2b_second_ar: got arvalid=%b araddr=%h required 1 00000200", arvalid, araddr);
    end
    wait_data_ok(c);
    checks++;
    if (c !== 3 || data_rdata !== 32'h2222_2222) begin
      errors++; $display("FAIL b2b_second_done: got cyc=%0d data=%h required 3 22222222", c, data_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    r_hold = 1'b1;
    issue(1'b0, 2'd2, 32'h0000_0400, 32'h0);
    @(negedge clk);
    data_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_rd_d: got rready=%b arvalid=%b required 1 0", rready, arvalid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || data_data_ok !== 1'b0 || data_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid_clear: got ar=%b r=%b ok=%b data=%h required 0 0 0 0",
                         arvalid, rready, data_data_ok, data_rdata);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    r_hold = 1'b0;
    data_req = 1'b1;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got %b required 1", data_addr_ok); end
    data_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_data_ok || arvalid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles required 0", seen); end
  endtask

  task automatic test_sizes();
    int c;
    issue(1'b1, 2'd1, 32'h0000_2002, 32'hBEEF_0000);
    @(negedge clk);
    data_req = 1'b0;
    checks++;
    if (wstrb !== 4'b1100 || awsize !== 3'b001) begin
      errors++; $display("FAIL half_fields: got strb=%b size=%b required 1100 001", wstrb, awsize);
    end
    wait_data_ok(c);
    @(negedge clk);
    issue(1'b1, 2'd3, 32'h0000_0010, 32'h0102_0304);
    @(negedge clk);
    data_req = 1'b0;
    checks++;
    if (wstrb !== 4'b1111 || awsize !== 3'b010 || wdata !== 32'h0102_0304) begin
      errors++; $display("FAIL size3_fields: got strb=%b size=%b wdata=%h required 1111 010 01020304",
                         wstrb, awsize, wdata);
    end
    wait_data_ok(c);
    checks++;
    if (c !== 3) begin errors++; $display("FAIL size3_done: got %0d required 3", c); end
    @(negedge clk);
  endtask

  task automatic test_addr_map();
    int c;
    logic [31:0] exp_rd, exp_wr;
`ifdef SRAM_LIKE_ADDR_MAP_EN
    exp_rd = 32'h1FC0_0000;
    exp_wr = 32'h0000_0010;
`else
    exp_rd = 32'hBFC0_0000;
    exp_wr = 32'h8000_0010;
`endif
    rd_val = 32'h0BAD_F00D;
    issue(1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
    @(negedge clk);
    data_req = 1'b0;
    checks++;
    if (araddr !== exp_rd) begin errors++; $display("FAIL map_araddr: got %h required %h", araddr, exp_rd); end
    wait_data_ok(c);
    @(negedge clk);
    issue(1'b1, 2'd2, 32'h8000_0010, 32'h5555_AAAA);
    @(negedge clk);
    data_req = 1'b0;
    checks++;
    if (awaddr !== exp_wr) begin errors++; $display("FAIL map_awaddr: got %h required %h", awaddr, exp_wr); end
    wait_data_ok(c);
    checks++;
    if (c !== 3) begin errors++; $display("FAIL map_wr_done: got %0d required 3", c); end
  endtask

  initial begin
    rst_n = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = '0; data_wdata = '0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    r_hold = 1'b0; rd_val = '0; rresp = 2'b00; bresp = 2'b00;
    test_reset();
    test_read();
    test_byte_write();
    test_split_handshake();
    test_back_to_back();
    test_reset_mid();
    test_sizes();
    test_addr_map();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
